dp_mod: RTL and testbench

//  Digital AM/FM modulator datapath. Takes a stream of signed baseband samples
//  and produces a modulated carrier sample for each one, in AM or FM mode.
//  The carrier comes from a 24-bit phase-accumulator NCO driving a quarter-wave

---
 rtl/dp_mod_pkg.sv | 56 +++++
 rtl/dp_mod_sin_lut.sv | 28 ++
 rtl/dp_mod.sv | 113 +++++++++++
 tb/tb_dp_mod.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_mod_pkg.sv
// Shared constants, types and the quarter-wave sine table for dp_mod.
// The table holds Q[k] = round(32767*sin(pi/2*k/256)), k = 0..256.
package dp_mod_pkg;

    localparam int LAT    = 3;
    localparam int PH_W   = 24;
    localparam int LUT_AW = 8;
    localparam int D_W    = 16;
    localparam int ENV_W  = 17;
    localparam int Q_N    = (1 << LUT_AW) + 1;

    localparam logic MODE_FM = 1'b1;
    localparam logic MODE_AM = 1'b0;

    // Envelope of 1.0 (unity gain) in the 17-bit envelope format.
    localparam logic [ENV_W-1:0] ENV_ONE = 17'h08000;

    typedef logic [Q_N-1:0][D_W-2:0] qtab_t;

    // Builds the table at elaboration time in Q.60 fixed point.
    // sin(k*th) follows s[k+1] = 2cos(th)*s[k] - s[k-1], th = pi/512;
    // the accumulated error stays far below the rounding step.
    function automatic qtab_t gen_qtab();
        qtab_t t;
        logic signed [127:0] one;
        logic signed [127:0] th;
        logic signed [127:0] th2;
        logic signed [127:0] th4;
        logic signed [127:0] th6;
        logic signed [127:0] c2;
        logic signed [127:0] sp;
        logic signed [127:0] sc;
        logic signed [127:0] sn;
        one = 128'sd1 <<< 60;
        // pi * 2^60, scaled down to pi/512
        th  = 128'sh3243F6A8885A308D >>> 9;
        th2 = (th * th) >>> 60;
        th4 = (th2 * th2) >>> 60;
        th6 = (th4 * th2) >>> 60;
        c2  = (one <<< 1) - th2 + th4 / 12 - th6 / 360;
        sc  = th - ((th2 * th) >>> 60) / 6
                 + ((th4 * th) >>> 60) / 120;
        sp  = '0;
        t   = '0;
        for (int k = 1; k < Q_N; k++) begin
            t[k[LUT_AW:0]] = 15'((sc * 32767 + (one >>> 1)) >>> 60);
            sn = ((c2 * sc) >>> 60) - sp;
            sp = sc;
            sc = sn;
        end
        return t;
    endfunction

    localparam qtab_t Q_TAB = gen_qtab();

endpackage

// File: rtl/dp_mod_sin_lut.sv
// Combinational sine lookup with quadrant folding over the quarter-wave table.
// Ports: i_phase = acc[23:14] (quadrant + 8-bit address), o_s = signed sine.
module dp_mod_sin_lut
    import dp_mod_pkg::*;
(
    input  logic [LUT_AW+1:0]      i_phase,
    output logic signed [D_W-1:0]  o_s
);

    logic [1:0]        w_q;
    logic [LUT_AW-1:0] w_a;
    logic [LUT_AW:0]   w_k;
    logic [D_W-2:0]    w_mag;

    assign w_q = i_phase[LUT_AW+1:LUT_AW];
    assign w_a = i_phase[LUT_AW-1:0];

    // Odd quadrants walk the quarter wave backwards: 256 - a.
    assign w_k = w_q[0] ? ({1'b1, {LUT_AW{1'b0}}} - {1'b0, w_a})
                        : {1'b0, w_a};

    assign w_mag = Q_TAB[w_k];

    // Lower half-cycle is the negated upper half.
    assign o_s = w_q[1] ? -$signed({1'b0, w_mag})
                        :  $signed({1'b0, w_mag});

endmodule

// File: rtl/dp_mod.sv
// AM/FM modulator: 3-stage datapath (inc/env, NCO accumulate, sine*env).
// Ports: clk, rst (sync, active low), i_data/val_in + config in, o_data/val_out out.
module dp_mod
    import dp_mod_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [D_W-1:0]  i_data,
    input  logic                   val_in,
    input  logic                   c_fm_am,
    input  logic [PH_W-1:0]        frec_por,
    input  logic [D_W-1:0]         im_am,
    input  logic [D_W-1:0]         im_fm,
    output logic signed [D_W-1:0]  o_data,
    output logic                   val_out
);

    localparam int P1 = 2 * D_W + 1;
    localparam int P3 = D_W + ENV_W + 1;

    localparam logic signed [P3-1:0] SAT_HI = 34'sd32767;
    localparam logic signed [P3-1:0] SAT_LO = -34'sd32768;

    logic [LAT-1:0]          r_vld;
    logic [PH_W-1:0]         r_inc;
    logic [ENV_W-1:0]        r_env1;
    logic [ENV_W-1:0]        r_env2;
    logic [PH_W-1:0]         r_acc;

    logic signed [P1-1:0]    w_data_x;
    logic signed [P1-1:0]    w_imfm_x;
    logic signed [P1-1:0]    w_imam_x;
    logic signed [P1-1:0]    w_fm_prod;
    logic signed [P1-1:0]    w_am_prod;
    logic signed [P1-1:0]    w_dev_sh;
    logic signed [P1-1:0]    w_am_sh;
    logic [PH_W-1:0]         w_inc;
    logic [ENV_W-1:0]        w_env;

    logic signed [D_W-1:0]   w_s;
    logic signed [P3-1:0]    w_s_x;
    logic signed [P3-1:0]    w_env_x;
    logic signed [P3-1:0]    w_out_prod;
    logic signed [P3-1:0]    w_out_sh;
    logic signed [D_W-1:0]   w_sat;

    // Stage 1: widen operands so the products never overflow.
    assign w_data_x  = {{(D_W+1){i_data[D_W-1]}}, i_data};
    assign w_imfm_x  = {{(D_W+1){1'b0}}, im_fm};
    assign w_imam_x  = {{(D_W+1){1'b0}}, im_am};
    assign w_fm_prod = w_data_x * w_imfm_x;
    assign w_am_prod = w_data_x * w_imam_x;
    assign w_dev_sh  = w_fm_prod >>> 8;
    assign w_am_sh   = w_am_prod >>> 16;

    always_comb begin
        w_inc = frec_por;
        w_env = ENV_ONE;
        unique case (c_fm_am)
            MODE_FM: w_inc = frec_por + PH_W'(w_dev_sh);
            // AM offset lies in [-32768, 32766], so the sum is 0..65534.
            MODE_AM: w_env = ENV_W'(w_am_sh) + ENV_ONE;
        endcase
    end

    // Stage 3: lookup on the already-updated accumulator.
    dp_mod_sin_lut u_lut (
        .i_phase (r_acc[PH_W-1:PH_W-LUT_AW-2]),
        .o_s     (w_s)
    );

    assign w_s_x      = {{(ENV_W+1){w_s[D_W-1]}}, w_s};
    assign w_env_x    = {{(D_W+1){1'b0}}, r_env2};
    assign w_out_prod = w_s_x * w_env_x;
    assign w_out_sh   = w_out_prod >>> 15;

    always_comb begin
        w_sat = D_W'(w_out_sh);
        if (w_out_sh > SAT_HI) begin
            w_sat = 16'sh7FFF;
        end else if (w_out_sh < SAT_LO) begin
            w_sat = 16'sh8000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld  <= '0;
            r_inc  <= '0;
            r_env1 <= '0;
            r_env2 <= '0;
            r_acc  <= '0;
            o_data <= '0;
        end else begin
            r_vld <= {r_vld[LAT-2:0], val_in};
            if (val_in) begin
                r_inc  <= w_inc;
                r_env1 <= w_env;
            end
            // Phase only advances on real samples; gaps keep it frozen.
            if (r_vld[0]) begin
                r_acc  <= r_acc + r_inc;
                r_env2 <= r_env1;
            end
            if (r_vld[1]) begin
                o_data <= w_sat;
            end
        end
    end

    assign val_out = r_vld[LAT-1];

endmodule

// File: tb/tb_dp_mod.sv
// Randomized and directed bench for dp_mod against a real-valued model.
// Model: NCO phase as an integer, sine via $sin, envelope via plain arithmetic.
module tb_dp_mod;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] i_data;
    logic               val_in;
    logic               c_fm_am;
    logic [23:0]        frec_por;
    logic [15:0]        im_am;
    logic [15:0]        im_fm;
    logic signed [15:0] o_data;
    logic               val_out;

    dp_mod dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .val_in   (val_in),
        .c_fm_am  (c_fm_am),
        .frec_por (frec_por),
        .im_am    (im_am),
        .im_fm    (im_fm),
        .o_data   (o_data),
        .val_out  (val_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     m_last = 0;
    longint m_acc  = 0;
    exp_t   sb[$];
    int     outs[$];

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Accept one sample: advance the model NCO and return the output.
    function automatic int model_accept(bit fm, int d, int frec,
                                        int ima, int imf);
        longint inc;
        longint env;
        longint p;
        longint y;
        real    r;
        int     s;
        if (fm) begin
            inc = longint'(frec) + ((longint'(d) * imf) >>> 8);
            env = 32768;
        end else begin
            inc = frec;
            env = 32768 + ((longint'(d) * ima) >>> 16);
        end
        m_acc = (m_acc + inc) & 64'hFFFFFF;
        p = m_acc >> 14;
        r = 32767.0 * $sin(2.0 * 3.14159265358979323846
                           * real'(p) / 1024.0);
        s = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        y = (longint'(s) * env) >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    // One clock: drive, update model at the edge, check #1 later.
    task automatic step(input bit r, input bit v, input bit fm,
                        input int d, input int frec,
                        input int ima, input int imf);
        exp_t e;
        rst      = r;
        val_in   = v;
        c_fm_am  = fm;
        i_data   = 16'(d);
        frec_por = 24'(frec);
        im_am    = 16'(ima);
        im_fm    = 16'(imf);
        @(posedge clk);
        cyc++;
        if (!r) begin
            sb.delete();
            m_acc  = 0;
            m_last = 0;
        end else if (v) begin
            e.due = cyc + 2;
            e.val = model_accept(fm, int'(i_data), int'(frec_por),
                                 int'(im_am), int'(im_fm));
            sb.push_back(e);
        end
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("val_out", val_out, 1);
            chk("o_data", o_data, sb[0].val);
            m_last = sb[0].val;
            outs.push_back(int'(o_data));
            void'(sb.pop_front());
        end else begin
            chk("val_out_idle", val_out, 0);
            chk("o_data_hold", o_data, m_last);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        outs.delete();
    endtask

    task automatic burst(input bit fm, input int d, input int frec,
                         input int ima, input int imf, input int n);
        for (int i = 0; i < n; i++) step(1, 1, fm, d, frec, ima, imf);
    endtask

    int seq_a[4] = '{32767, 0, -32767, 0};
    int seq_s[4] = '{32767, 0, -32768, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; val_in = 1'b0; c_fm_am = 1'b0; i_data = '0;
        frec_por = '0; im_am = '0; im_fm = '0;

        // Reset held with val_in high: nothing may come out.
        for (int i = 0; i < 10; i++)
            step(0, 1, 1, int'($urandom), 24'h400000, 0, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_val_out", val_out, 0);
        idle(2);
        outs.delete();
        step(1, 1, 1, 0, 24'h400000, 0, 0);
        idle(5);
        chk("pulse_cnt", outs.size(), 1);

        // FM, zero deviation, quarter-cycle steps.
        do_reset();
        burst(1, int'($urandom), 24'h400000, 0, 0, 8);
        idle(3);
        chk("t2_cnt", outs.size(), 8);
        for (int i = 0; i < 8 && i < outs.size(); i++)
            chk($sformatf("t2_%0d", i), outs[i], seq_a[i % 4]);

        // AM with zero index: unity envelope, same sequence.
        do_reset();
        burst(0, int'($urandom), 24'h400000, 0, 0, 8);
        idle(3);
        chk("t3_cnt", outs.size(), 8);
        for (int i = 0; i < 8 && i < outs.size(); i++)
            chk($sformatf("t3_%0d", i), outs[i], seq_a[i % 4]);

        // AM full index: saturation at max, silence at min.
        do_reset();
        burst(0, 32767, 24'h400000, 65535, 0, 4);
        burst(0, -32768, 24'h400000, 65535, 0, 4);
        idle(3);
        chk("t4_cnt", outs.size(), 8);
        for (int i = 0; i < 8 && i < outs.size(); i++)
            chk($sformatf("t4_%0d", i), outs[i],
                (i < 4) ? seq_s[i] : 0);

        // FM deviation only: inc = 0x4000 per sample.
        do_reset();
        burst(1, 16384, 0, 0, 256, 64);
        idle(3);
        chk("t5_cnt", outs.size(), 64);
        if (outs.size() == 64) begin
            chk("t5_first", outs[0], 201);
            chk("t5_64th", outs[63], 12539);
        end

        // Mode switching with gaps, then reset with samples in flight.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, i[0], int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom_range(0, 1023)));
            if (i % 3 == 0) idle(1);
        end
        step(1, 1, 1, 1000, 24'h123456, 0, 300);
        step(1, 1, 0, -5000, 24'h654321, 40000, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        outs.delete();
        step(1, 1, 1, 0, 24'h400000, 0, 0);
        idle(4);
        chk("t6_cnt", outs.size(), 1);
        if (outs.size() > 0) chk("t6_phase0", outs[0], 32767);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)),
                 int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom));
        end
        idle(4);
        chk("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
